// File: rtl/bf16_mul_arbiter_pkg.sv
// Shared BF16 definitions for the multiplier arbiter slice.
package bf16_pkg;

   localparam int unsigned BF16_W = 16;

   localparam int unsigned FLG_EXC = 2;
   localparam int unsigned FLG_OVF = 1;
   localparam int unsigned FLG_UNF = 0;

   typedef logic [BF16_W-1:0] bf16_t;

endpackage : bf16_pkg

// File: rtl/bf16_mul_arbiter_bf16mul.sv
// Combinational BF16 multiplier: truncating, subnormal inputs treated as zero,
// NaN/Inf inputs raise Exception, out-of-range exponents raise Overflow/Underflow.
module BF16mul
   import bf16_pkg::*;
(
   input  bf16_t a,
   input  bf16_t b,
   output logic  Exception,
   output logic  Overflow,
   output logic  Underflow,
   output bf16_t result
);

   logic              sa, sb, sr;
   logic [7:0]        ea, eb;
   logic [6:0]        ma, mb;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [15:0]       prod;
   logic              norm;
   logic signed [9:0] exp_r;
   logic [6:0]        mant_r;

   always_comb begin
      {sa, ea, ma} = a;
      {sb, eb, mb} = b;
      sr     = sa ^ sb;
      a_nan  = (ea == '1) && (ma != '0);
      b_nan  = (eb == '1) && (mb != '0);
      a_inf  = (ea == '1) && (ma == '0);
      b_inf  = (eb == '1) && (mb == '0);
      a_zero = (ea == '0);
      b_zero = (eb == '0);

      prod   = 16'({1'b1, ma}) * 16'({1'b1, mb});
      norm   = prod[15];
      exp_r  = $signed({2'b00, ea}) + $signed({2'b00, eb})
             + $signed({9'd0, norm}) - 10'sd127;
      // Product of two [1,2) significands lies in [1,4); drop the hidden bit after normalising.
      mant_r = norm ? 7'(prod >> 8) : 7'(prod >> 7);

      Exception = 1'b0;
      Overflow  = 1'b0;
      Underflow = 1'b0;
      result    = {sr, 15'h0000};

      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         Exception = 1'b1;
         result    = 16'h7FC0;
      end else if (a_inf || b_inf) begin
         Exception = 1'b1;
         result    = {sr, 8'hFF, 7'h00};
      end else if (a_zero || b_zero) begin
         result    = {sr, 15'h0000};
      end else if (exp_r > 10'sd254) begin
         Overflow  = 1'b1;
         result    = {sr, 8'hFF, 7'h00};
      end else if (exp_r < 10'sd1) begin
         Underflow = 1'b1;
         result    = {sr, 15'h0000};
      end else begin
         result    = {sr, exp_r[7:0], mant_r};
      end
   end

endmodule : BF16mul

// File: rtl/bf16_mul_arbiter.sv
// Round-robin arbiter sharing one BF16mul among N_REQ requesters through a
// two-stage (operand / response) pipeline with valid/ready on both sides.
module bf16_mul_arbiter
   import bf16_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [BF16_W*N_REQ-1:0]   req_a,
   input  logic [BF16_W*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [BF16_W-1:0]         rsp_result,
   output logic [2:0]                rsp_flags
);

   logic              s1_valid;
   bf16_t             s1_a, s1_b;
   logic [ID_W-1:0]   s1_id;

   logic              s2_valid;
   bf16_t             s2_result;
   logic [2:0]        s2_flags;
   logic [ID_W-1:0]   s2_id;

   logic [ID_W-1:0]   rr_ptr, rr_next, win_id;
   logic [N_REQ-1:0]  grant;
   logic              found;
   logic              s1_adv, s2_adv, accept;
   bf16_t             win_a, win_b;

   logic              mul_exc, mul_ovf, mul_unf;
   bf16_t             mul_res;

   assign s2_adv = !s2_valid || rsp_ready;
   assign s1_adv = !s1_valid || s2_adv;

   // Scan from rr_ptr upward with wrap; the first valid requester wins.
   always_comb begin
      grant  = '0;
      win_id = '0;
      found  = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         int unsigned idx;
         idx = (32'(rr_ptr) + k) % N_REQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win_id     = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n) req_ready = grant & {N_REQ{s1_adv}};
   end

   assign accept  = |req_ready;
   assign rr_next = (32'(win_id) == N_REQ - 1) ? '0 : win_id + ID_W'(1);
   assign win_a   = req_a[32'(win_id)*BF16_W +: BF16_W];
   assign win_b   = req_b[32'(win_id)*BF16_W +: BF16_W];

   BF16mul u_mul (s1_a, s1_b, mul_exc, mul_ovf, mul_unf, mul_res);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_id     <= '0;
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_flags  <= '0;
         s2_id     <= '0;
         rr_ptr    <= '0;
      end else begin
         if (s1_adv) begin
            if (accept) begin
               s1_valid <= 1'b1;
               s1_a     <= win_a;
               s1_b     <= win_b;
               s1_id    <= win_id;
               rr_ptr   <= rr_next;
            end else begin
               s1_valid <= 1'b0;
            end
         end
         if (s2_adv) begin
            s2_valid           <= s1_valid;
            s2_result          <= mul_res;
            s2_flags[FLG_EXC]  <= mul_exc;
            s2_flags[FLG_OVF]  <= mul_ovf;
            s2_flags[FLG_UNF]  <= mul_unf;
            s2_id              <= s1_id;
         end
      end
   end

   assign rsp_valid  = s2_valid;
   assign rsp_result = s2_result;
   assign rsp_flags  = s2_flags;
   assign rsp_id     = s2_id;

endmodule : bf16_mul_arbiter

// File: tb/tb_bf16_mul_arbiter.sv
// Directed bench for bf16_mul_arbiter: reset, round-robin order, backpressure,
// exception flags, random sweep against a standalone BF16mul, mid-flight reset.
module tb_bf16_mul_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [63:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_flags;

   logic [15:0] ref_a, ref_b, ref_res;
   logic        ref_exc, ref_ovf, ref_unf;

   int checks = 0;
   int errors = 0;

   logic [3:0]  exp_rdy [0:5];
   logic [15:0] res_by_id [0:3];

   always #5 clk = ~clk;

   bf16_mul_arbiter #(.N_REQ(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
   );

   BF16mul u_ref (ref_a, ref_b, ref_exc, ref_ovf, ref_unf, ref_res);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
   endtask

   // One isolated transaction from requester i; rand_rdy stalls the response randomly.
   task automatic do_one(input string tag, input int i, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er,
                         input logic [2:0] ef, input bit rand_rdy);
      bit found, seen, done;
      found = 0; seen = 0; done = 0;
      set_op(i, a, b);
      req_valid = 4'(1 << i);
      rsp_ready = 1'b1;
      for (int c = 0; c < 8 && !found; c++) begin
         #1;
         if (req_ready[i]) found = 1;
         else tick();
      end
      chk({tag, " accept"}, 32'(found), 32'd1);
      tick();
      req_valid = '0;
      for (int c = 0; c < 40 && !done; c++) begin
         rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         if (rsp_valid) begin
            if (!seen) chk(tag, {11'h0, rsp_id, rsp_flags, rsp_result},
                           {11'h0, 2'(i), ef, er});
            seen = 1;
            if (rsp_ready) done = 1;
         end
         tick();
      end
      chk({tag, " drained"}, 32'(done), 32'd1);
      rsp_ready = 1'b1;
   endtask

   initial begin
      logic [15:0] ra, rb;
      int          ri;
      rst_n     = 1'b0;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      ref_a     = '0;
      ref_b     = '0;
      set_op(0, 16'h4000, 16'h4040);
      set_op(1, 16'hBF80, 16'h4000);
      set_op(2, 16'h3FC0, 16'h3FC0);
      set_op(3, 16'h0000, 16'h40A0);
      exp_rdy   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
      res_by_id = '{16'h40C0, 16'hC000, 16'h4010, 16'h0000};

      for (int k = 0; k < 3; k++) begin
         tick();
         chk("reset req_ready", 32'(req_ready), 32'h0);
         chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
         chk("reset rsp_result", 32'(rsp_result), 32'h0);
         chk("reset rsp_flags", 32'(rsp_flags), 32'h0);
      end
      rst_n = 1'b1;
      #1;

      for (int k = 0; k < 8; k++) begin
         if (k <= 5) chk("rr req_ready", 32'(req_ready), 32'(exp_rdy[k]));
         if (k == 5) req_valid = '0;
         chk("rr rsp_valid", 32'(rsp_valid), 32'(k >= 2 && k <= 6));
         if (k >= 2 && k <= 6) begin
            chk("rr rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
            chk("rr rsp_result", 32'(rsp_result), 32'(res_by_id[(k - 2) % 4]));
            chk("rr rsp_flags", 32'(rsp_flags), 32'h0);
         end
         tick();
      end

      req_valid = 4'b0100;
      #1;
      chk("single req_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      chk("single lat1 rsp_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("single rsp", {11'h0, rsp_valid, rsp_id, rsp_flags, rsp_result},
          {11'h0, 1'b1, 2'd2, 3'b000, 16'h4010});
      tick();
      chk("single one-only", 32'(rsp_valid), 32'h0);

      rsp_ready = 1'b0;
      req_valid = 4'hF;
      #1;
      chk("bp req_ready c0", 32'(req_ready), 32'h8);
      tick();
      chk("bp req_ready c1", 32'(req_ready), 32'h1);
      tick();
      for (int k = 2; k <= 4; k++) begin
         chk("bp stall req_ready", 32'(req_ready), 32'h0);
         chk("bp hold rsp", {11'h0, rsp_valid, rsp_id, rsp_flags, rsp_result},
             {11'h0, 1'b1, 2'd3, 3'b000, 16'h0000});
         tick();
      end
      chk("bp still stalled", 32'(req_ready), 32'h0);
      rsp_ready = 1'b1;
      req_valid = 4'b0010;
      #1;
      chk("bp refill req_ready", 32'(req_ready), 32'h2);
      chk("bp drain id", 32'(rsp_id), 32'h3);
      tick();
      req_valid = '0;
      chk("bp rsp r0", {11'h0, rsp_valid, rsp_id, rsp_flags, rsp_result},
          {11'h0, 1'b1, 2'd0, 3'b000, 16'h40C0});
      tick();
      chk("bp rsp r1", {11'h0, rsp_valid, rsp_id, rsp_flags, rsp_result},
          {11'h0, 1'b1, 2'd1, 3'b000, 16'hC000});
      tick();
      chk("bp empty", 32'(rsp_valid), 32'h0);

      do_one("ovf",     0, 16'h7F00, 16'h7F00, 16'h7F80, 3'b010, 1'b0);
      do_one("unf",     1, 16'h0080, 16'h0080, 16'h0000, 3'b001, 1'b0);
      do_one("inf",     2, 16'h7F80, 16'h4000, 16'h7F80, 3'b100, 1'b0);
      do_one("inf*0",   3, 16'h7F80, 16'h0000, 16'h7FC0, 3'b100, 1'b0);
      do_one("nan",     0, 16'h7FC1, 16'h3F80, 16'h7FC0, 3'b100, 1'b0);
      do_one("neg*neg", 1, 16'hC000, 16'hC000, 16'h4080, 3'b000, 1'b0);

      ref_a = 16'h7F00;
      ref_b = 16'h7F00;
      #1;
      do_one("ovf vs ref", 2, 16'h7F00, 16'h7F00, ref_res,
             {ref_exc, ref_ovf, ref_unf}, 1'b0);

      for (int n = 0; n < 10000; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         ri = $urandom_range(0, 3);
         ref_a = ra;
         ref_b = rb;
         #1;
         do_one("sweep", ri, ra, rb, ref_res, {ref_exc, ref_ovf, ref_unf}, 1'b1);
      end

      rsp_ready = 1'b0;
      req_valid = 4'hF;
      tick();
      tick();
      chk("mid full rsp_valid", 32'(rsp_valid), 32'h1);
      chk("mid full req_ready", 32'(req_ready), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("mid rst req_ready", 32'(req_ready), 32'h0);
      tick();
      chk("mid after rst rsp_valid", 32'(rsp_valid), 32'h0);
      rst_n     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mid no stale rsp", 32'(rsp_valid), 32'h0);
      end
      req_valid = 4'hF;
      #1;
      chk("mid ptr reset", 32'(req_ready), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_bf16_mul_arbiter

// File: doc/bf16_mul_arbiter.md
# bf16_mul_arbiter

Shares one combinational `BF16mul` instance among `N_REQ` requesters, such as systolic-array PE rows or a vector unit, using round-robin arbitration. Each requester submits an operand pair through a valid/ready handshake. The block registers the winning operands, multiplies them, and returns the result, the three exception flags and the requester ID through a registered response port. The response port honours backpressure. Sustained throughput is one multiply per cycle.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, $clog2(N_REQ): requester ID width, derived; do not override.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  bit i: requester i has an operand pair.
- `req_a`  in  16*N_REQ  BF16 operand A; requester i at [16i+15:16i].
- `req_b`  in  16*N_REQ  BF16 operand B; same packing as `req_a`.
- `req_ready`  out  N_REQ  one-hot or zero; bit i high means requester i's pair is accepted this cycle.
- `rsp_valid`  out  1  response holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  index of the requester that issued this result.
- `rsp_result`  out  16  BF16 product from `BF16mul`.
- `rsp_flags`  out  3  {Exception, Overflow, Underflow} from `BF16mul`, unmodified.

## Operation
- Two register stages: S1 holds the operand pair, S2 holds the response.
- S1 stores {a, b, id, s1_valid}; `BF16mul` computes combinationally from S1.
- S2 stores {result, flags, id, s2_valid} and drives the `rsp_*` outputs directly.
- `s2_adv = !s2_valid || rsp_ready`.
- `s1_adv = !s1_valid || s2_adv`.
- Arbitration:
  - Round-robin pointer `rr_ptr` (ID_W bits). The highest-priority index is `rr_ptr`, then ascending with wrap modulo N_REQ.
  - `grant` is the one-hot first set bit of `req_valid` in that order.
  - `req_ready = grant & {N_REQ{s1_adv}}`.
- On an accepted handshake (`|req_ready`):
  - S1 loads the winner's operands and ID.
  - `rr_ptr` becomes (winner + 1) mod N_REQ.
  - `rr_ptr` does not move when nothing is accepted.
- If `s1_adv` holds and no request is valid, `s1_valid` clears.
- If `s2_adv` holds:
  - S2 loads the `BF16mul` outputs and the ID from S1.
  - `s2_valid` is set to `s1_valid`.
- If `s2_adv` is low, S2 holds every field, and S1 also holds if it is valid.
- Requesters must keep `req_a`/`req_b` stable while `req_valid` is high and not yet accepted. The block does not check this.
- Each requester's results are returned in issue order. The global response order equals the grant order.
- Reset (synchronous, `rst_n`=0 at a rising edge):
  - `s1_valid`=0, `s2_valid`=0, `rr_ptr`=0.
  - Data registers are cleared to 0: `rsp_result`=16'h0000, `rsp_flags`=3'b000, `rsp_id`=0.
  - `req_ready` is forced to 0 while `rst_n` is low.
- Reset mid-operation drops any in-flight S1/S2 contents with no response. Requesters must re-issue.

## Timing
- Latency: a handshake at edge t produces `rsp_valid`=1 after edge t+1, meaning visible in the cycle after S1 has loaded. This is 2 edges from acceptance to S2 load.
- Throughput: with `rsp_ready` tied high, one accept per cycle and one response per cycle.
- Capacity: at most 2 transactions in flight (S1 + S2). While `rsp_ready` is low and both stages are full, `req_ready` = 0.
- Combinational paths:
  - `rsp_ready` → `req_ready` (through `s2_adv`/`s1_adv`).
  - `req_valid` → `req_ready`.
  - There is no path from `req_*` to `rsp_*`.
- Simultaneous S2 drain and S1 refill in the same cycle is required; no bubble is allowed.
- Fairness: with all requesters continuously valid, each is granted exactly once per N_REQ accepted handshakes.

## Structure
- Package `bf16_pkg`:
  - `BF16_W`=16.
  - Flag indices `FLG_EXC`=2, `FLG_OVF`=1, `FLG_UNF`=0.
  - Type `bf16_t` as a 16-bit logic vector.
- One sub-module: the existing `BF16mul`, instantiated once between S1 and S2, ports connected positionally (a, b, Exception, Overflow, Underflow, result).
- The round-robin grant logic stays inline; no separate arbiter module.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with all `req_valid`=1 → `req_ready`=0, `rsp_valid`=0, `rsp_result`=16'h0000, `rsp_flags`=0 throughout. After release, the first grant goes to requester 0.
- Single multiply: requester 2 sends a=16'h3FC0, b=16'h3FC0 (1.5×1.5) with `rsp_ready`=1 → 2 edges later `rsp_valid`=1, `rsp_result`=16'h4010, `rsp_flags`=0, `rsp_id`=2; one response only.
- Round-robin: all four requesters held valid with distinct operands, `rsp_ready`=1 → grants in order 0,1,2,3,0 on consecutive cycles; responses follow with matching IDs and one result per cycle.
- Backpressure: continuous requests, `rsp_ready`=0 for 5 cycles →
  - the response holds stable;
  - exactly 2 handshakes occur before `req_ready` drops to 0;
  - after `rsp_ready` returns to 1, there is no loss or duplication and IDs stay in grant order.
- Flags: a=16'h7F00, b=16'h7F00 → `rsp_flags[FLG_OVF]`=1, with result and flags identical to a standalone `BF16mul` given the same inputs; also run a 10000-vector random sweep against the standalone `BF16mul` model with random `rsp_ready`.
- Mid-flight reset: assert `rst_n`=0 for 1 cycle while S1 and S2 are both valid → the next cycle has `rsp_valid`=0, and no stale response appears afterwards.
